// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the micro-op sequencer: state encodings, default opcodes
// and instruction field positions used by the CPU top and the ALU.
package alu_op_sequencer_pkg;

   localparam int STATE_W = 4;

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_LD_A = 4'd1;
   localparam logic [3:0] S_LD_B = 4'd2;
   localparam logic [3:0] S_T0   = 4'd3;
   localparam logic [3:0] S_T1   = 4'd4;
   localparam logic [3:0] S_T2   = 4'd5;
   localparam logic [3:0] S_T3   = 4'd6;
   localparam logic [3:0] S_T4   = 4'd7;
   localparam logic [3:0] S_T5   = 4'd8;
   localparam logic [3:0] S_T6   = 4'd9;
   localparam logic [3:0] S_DONE = 4'd10;

   localparam logic [4:0] OPC_MUL_DEF = 5'b01111;
   localparam logic [4:0] OPC_DIV_DEF = 5'b10000;

   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;

   function automatic logic [4:0] instr_opc(input logic [31:0] w);
      return w[OPC_LSB +: 5];
   endfunction

   function automatic logic [3:0] instr_ra(input logic [31:0] w);
      return w[RA_LSB +: 4];
   endfunction

   function automatic logic [3:0] instr_rb(input logic [31:0] w);
      return w[RB_LSB +: 4];
   endfunction

   function automatic logic [3:0] instr_rc(input logic [31:0] w);
      return w[RC_LSB +: 4];
   endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_onehot_decoder.sv
// Binary register index to one-hot select; all-zero when disabled.
module reg_onehot_decoder #(
   parameter int NREGS = 16,
   localparam int RW = $clog2(NREGS)
) (
   input  logic             en_i,
   input  logic [RW-1:0]    idx_i,
   output logic [NREGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore micro-op sequencer: optional register preload through MDR, then
// fetch (T0-T2) and execute (T3-T5, plus T6 for two-result MUL/DIV).
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int         DATA_W      = 32,
   parameter int         NREGS       = 16,
   parameter int         NUM_PRELOAD = 4,
   parameter logic [4:0] OPC_MUL     = OPC_MUL_DEF,
   parameter logic [4:0] OPC_DIV     = OPC_DIV_DEF,
   localparam int        IDX_W       = $clog2(NUM_PRELOAD),
   localparam int        CNT_W       = IDX_W + 1,
   localparam int        RW          = $clog2(NREGS)
) (
   input  logic              Clock,
   input  logic              clear,
   input  logic              pl_wr_en,
   input  logic [IDX_W-1:0]  pl_wr_idx,
   input  logic [RW-1:0]     pl_wr_reg,
   input  logic [DATA_W-1:0] pl_wr_data,
   input  logic [CNT_W-1:0]  preload_cnt,
   input  logic [31:0]       instr,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] Mdatain,
   output logic              PCout,
   output logic              Zlowout,
   output logic              Zhighout,
   output logic              MDRout,
   output logic              MARin,
   output logic              Zin,
   output logic              PCin,
   output logic              MDRin,
   output logic              IRin,
   output logic              Yin,
   output logic              IncPC,
   output logic              Read,
   output logic              HIin,
   output logic              LOin,
   output logic [NREGS-1:0]  Rin,
   output logic [NREGS-1:0]  Rout,
   output logic [4:0]        alu_op
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   idx_q, idx_d, cnt_q, cnt_clamped, idx_inc;
   logic [31:0]        instr_q;
   logic [DATA_W-1:0]  pl_data_q [NUM_PRELOAD];
   logic [RW-1:0]      pl_reg_q  [NUM_PRELOAD];
   logic [IDX_W-1:0]   entry;
   logic [4:0]         opc;
   logic               start_acc, two_result;
   logic               rin_en, rout_en;
   logic [RW-1:0]      rin_sel, rout_sel;

   assign start_acc   = (state_q == S_IDLE) && start;
   assign cnt_clamped = (preload_cnt > CNT_W'(NUM_PRELOAD)) ? CNT_W'(NUM_PRELOAD) : preload_cnt;
   assign idx_inc     = idx_q + CNT_W'(1);
   assign entry       = idx_q[IDX_W-1:0];
   assign opc         = instr_opc(instr_q);
   assign two_result  = (opc == OPC_MUL) || (opc == OPC_DIV);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = (cnt_clamped != '0) ? S_LD_A : S_T0;
            end
         end
         S_LD_A: state_d = S_LD_B;
         S_LD_B: begin
            idx_d   = idx_inc;
            state_d = (idx_inc < cnt_q) ? S_LD_A : S_T0;
         end
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3:   state_d = S_T4;
         S_T4:   state_d = S_T5;
         S_T5:   state_d = two_result ? S_T6 : S_DONE;
         S_T6:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Table writes are locked out while busy so a run sees a stable table.
   always_ff @(posedge Clock) begin
      if (start_acc) begin
         instr_q <= instr;
         cnt_q   <= cnt_clamped;
      end
      if (pl_wr_en && (state_q == S_IDLE)) begin
         pl_data_q[pl_wr_idx] <= pl_wr_data;
         pl_reg_q[pl_wr_idx]  <= pl_wr_reg;
      end
   end

   assign rin_en   = (state_q == S_LD_B) || ((state_q == S_T5) && !two_result);
   assign rin_sel  = (state_q == S_LD_B) ? pl_reg_q[entry] : RW'(instr_ra(instr_q));
   assign rout_en  = (state_q == S_T3) || (state_q == S_T4);
   assign rout_sel = (state_q == S_T3) ? RW'(instr_rb(instr_q)) : RW'(instr_rc(instr_q));

   reg_onehot_decoder #(.NREGS(NREGS)) u_rin_dec (
      .en_i     (rin_en),
      .idx_i    (rin_sel),
      .onehot_o (Rin)
   );

   reg_onehot_decoder #(.NREGS(NREGS)) u_rout_dec (
      .en_i     (rout_en),
      .idx_i    (rout_sel),
      .onehot_o (Rout)
   );

   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      Mdatain  = '0;
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      Zin      = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      alu_op   = '0;
      case (state_q)
         S_LD_A: begin
            Mdatain = pl_data_q[entry];
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_LD_B: MDRout = 1'b1;
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            Mdatain = DATA_W'(instr_q);
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: Yin = 1'b1;
         S_T4: begin
            alu_op = opc;
            Zin    = 1'b1;
         end
         S_T5: begin
            Zlowout = 1'b1;
            LOin    = two_result;
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer against a micro-step trace model.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [31:0] md;
      logic [13:0] st;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  op;
   } obs_t;

   localparam logic [13:0] M_PCOUT = 14'(1 << 13);
   localparam logic [13:0] M_ZLOW  = 14'(1 << 12);
   localparam logic [13:0] M_ZHIGH = 14'(1 << 11);
   localparam logic [13:0] M_MDROUT= 14'(1 << 10);
   localparam logic [13:0] M_MARIN = 14'(1 << 9);
   localparam logic [13:0] M_ZIN   = 14'(1 << 8);
   localparam logic [13:0] M_PCIN  = 14'(1 << 7);
   localparam logic [13:0] M_MDRIN = 14'(1 << 6);
   localparam logic [13:0] M_IRIN  = 14'(1 << 5);
   localparam logic [13:0] M_YIN   = 14'(1 << 4);
   localparam logic [13:0] M_INCPC = 14'(1 << 3);
   localparam logic [13:0] M_READ  = 14'(1 << 2);
   localparam logic [13:0] M_HIIN  = 14'(1 << 1);
   localparam logic [13:0] M_LOIN  = 14'(1 << 0);

   logic        Clock, clear, pl_wr_en, start;
   logic [1:0]  pl_wr_idx;
   logic [3:0]  pl_wr_reg;
   logic [31:0] pl_wr_data, instr, Mdatain;
   logic [2:0]  preload_cnt;
   logic        busy, done, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin;
   logic        MDRin, IRin, Yin, IncPC, Read, HIin, LOin;
   logic [15:0] Rin, Rout;
   logic [4:0]  alu_op;

   int   n_chk, n_bad;
   obs_t exp_q[$];
   obs_t snap [0:40];
   logic [3:0]  tbl_reg  [4];
   logic [31:0] tbl_data [4];

   alu_op_sequencer dut (
      .Clock(Clock), .clear(clear), .pl_wr_en(pl_wr_en), .pl_wr_idx(pl_wr_idx),
      .pl_wr_reg(pl_wr_reg), .pl_wr_data(pl_wr_data), .preload_cnt(preload_cnt),
      .instr(instr), .start(start), .busy(busy), .done(done), .Mdatain(Mdatain),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .IncPC(IncPC), .Read(Read), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
      .alu_op(alu_op)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.busy = busy;
      o.done = done;
      o.md   = Mdatain;
      o.st   = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                IncPC, Read, HIin, LOin};
      o.rin  = Rin;
      o.rout = Rout;
      o.op   = alu_op;
      return o;
   endfunction

   // Expected cycle-by-cycle trace (cycles 1..N after the start cycle) built from the micro-step list.
   function automatic void build(input int cnt_raw, input logic [31:0] iw);
      obs_t e;
      int   c;
      logic [4:0] opc;
      bit   two;
      c   = (cnt_raw > 4) ? 4 : cnt_raw;
      opc = iw[31:27];
      two = (opc == 5'b01111) || (opc == 5'b10000);
      exp_q.delete();
      for (int i = 0; i < c; i++) begin
         e = '0; e.busy = 1'b1; e.md = tbl_data[i]; e.st = M_READ | M_MDRIN;
         exp_q.push_back(e);
         e = '0; e.busy = 1'b1; e.st = M_MDROUT; e.rin = 16'(1) << tbl_reg[i];
         exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.st = M_PCOUT | M_MARIN | M_INCPC | M_ZIN; exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.st = M_ZLOW | M_PCIN | M_READ | M_MDRIN; e.md = iw; exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.st = M_MDROUT | M_IRIN; exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.st = M_YIN; e.rout = 16'(1) << iw[22:19]; exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.st = M_ZIN; e.rout = 16'(1) << iw[18:15]; e.op = opc;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1;
      if (two) e.st = M_ZLOW | M_LOIN;
      else begin
         e.st  = M_ZLOW;
         e.rin = 16'(1) << iw[26:23];
      end
      exp_q.push_back(e);
      if (two) begin
         e = '0; e.busy = 1'b1; e.st = M_ZHIGH | M_HIIN; exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
   endfunction

   task automatic load(input int idx, input logic [3:0] r, input logic [31:0] d);
      @(posedge Clock); #1;
      pl_wr_en = 1'b1; pl_wr_idx = 2'(idx); pl_wr_reg = r; pl_wr_data = d;
      tbl_reg[idx] = r; tbl_data[idx] = d;
      @(posedge Clock); #1;
      pl_wr_en = 1'b0;
   endtask

   task automatic run(input string nm, input int cnt_raw, input logic [31:0] iw,
                      input int restart_at, input int clear_at, input int plwr_at, input bit chain);
      int   n;
      obs_t e;
      build(cnt_raw, iw);
      n = exp_q.size();
      @(posedge Clock); #1;
      preload_cnt = 3'(cnt_raw); instr = iw; start = 1'b1;
      @(negedge Clock);
      snap[0] = observe();
      check($sformatf("%s_c0", nm), snap[0], 96'h0);
      for (int k = 1; k <= n; k++) begin
         @(posedge Clock); #1;
         start = (k == restart_at);
         clear = (k == clear_at);
         pl_wr_en = (k == plwr_at);
         pl_wr_idx = 2'd3; pl_wr_reg = 4'd0; pl_wr_data = 32'hDEAD_BEEF;
         if (k == restart_at) begin
            instr = $urandom;
            preload_cnt = 3'd1;
         end
         @(negedge Clock);
         snap[k] = observe();
         e = (clear_at > 0 && k > clear_at) ? '0 : exp_q[k-1];
         check($sformatf("%s_c%0d", nm, k), snap[k], e);
         if (clear_at > 0 && k == clear_at + 1) break;
      end
      if (!chain) begin
         @(posedge Clock); #1;
         start = 1'b0; clear = 1'b0; pl_wr_en = 1'b0;
         @(negedge Clock);
         check($sformatf("%s_tail", nm), observe(), 96'h0);
      end
   endtask

   initial begin
      n_chk = 0; n_bad = 0;
      clear = 1'b1; start = 1'b0; pl_wr_en = 1'b0; pl_wr_idx = '0; pl_wr_reg = '0;
      pl_wr_data = '0; preload_cnt = '0; instr = '0;

      // Reset held two cycles.
      for (int i = 0; i < 2; i++) begin
         @(posedge Clock); #1;
         @(negedge Clock);
         check($sformatf("rst_all_%0d", i), observe(), 96'h0);
         check($sformatf("rst_busy_%0d", i), busy, 1'b0);
      end
      clear = 1'b0;

      // AND run with three preloads.
      load(0, 4'd2, 32'h22); load(1, 4'd4, 32'h24); load(2, 4'd5, 32'h26);
      run("and", 3, 32'h4A92_0000, -1, -1, -1, 1'b0);
      check("and_c2_rin", snap[2].rin, 16'h0004);
      check("and_c10_rout", snap[10].rout, 16'h0004);
      check("and_c10_st", snap[10].st, M_YIN);
      check("and_c11_rout", snap[11].rout, 16'h0010);
      check("and_c11_op", snap[11].op, 5'b01001);
      check("and_c11_st", snap[11].st, M_ZIN);
      check("and_c12_st", snap[12].st, M_ZLOW);
      check("and_c12_rin", snap[12].rin, 16'h0020);
      check("and_c13_done", snap[13].done, 1'b1);
      check("and_c12_done", snap[12].done, 1'b0);

      // MUL with no preload.
      run("mul", 0, {5'b01111, 4'd3, 4'd1, 4'd2, 15'd0}, -1, -1, -1, 1'b0);
      check("mul_c1_st", snap[1].st, M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
      check("mul_c6_st", snap[6].st, M_ZLOW | M_LOIN);
      check("mul_c6_rin", snap[6].rin, 16'h0000);
      check("mul_c7_st", snap[7].st, M_ZHIGH | M_HIIN);
      check("mul_c8_done", snap[8].done, 1'b1);

      // Start during T2 ignored, then a start right after done is accepted.
      run("rst2", 3, 32'h4A92_0000, 9, -1, -1, 1'b1);
      run("b2b", 1, {5'b10000, 4'd7, 4'd8, 4'd9, 15'd0}, -1, -1, -1, 1'b0);
      check("b2b_c1_busy", snap[1].busy, 1'b1);

      // Clear during T4, then a clean rerun.
      run("clr", 3, 32'h4A92_0000, -1, 11, -1, 1'b0);
      check("clr_c12_busy", snap[12].busy, 1'b0);
      run("rerun", 3, 32'h4A92_0000, -1, -1, -1, 1'b0);
      check("rerun_c11_op", snap[11].op, 5'b01001);
      check("rerun_c13_done", snap[13].done, 1'b1);

      // Oversized count clamps to the table depth; a table write mid-run is dropped.
      load(3, 4'd9, 32'h0000_0999);
      run("cap", 7, 32'h0A92_8000, -1, -1, 1, 1'b0);
      check("cap_c7_md", snap[7].md, 32'h0000_0999);
      check("cap_c8_rin", snap[8].rin, 16'h0200);
      check("cap_c9_st", snap[9].st, M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
      check("cap_c15_done", snap[15].done, 1'b1);

      // Randomized runs.
      for (int r = 0; r < 10; r++) begin
         logic [31:0] w;
         for (int i = 0; i < 4; i++) load(i, 4'($urandom_range(0, 15)), $urandom);
         w = $urandom;
         case ($urandom_range(0, 2))
            0: w[31:27] = 5'b01111;
            1: w[31:27] = 5'b10000;
            default: ;
         endcase
         run($sformatf("rnd%0d", r), $urandom_range(0, 7), w, -1, -1, -1, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
